// File: rtl/sram_like_to_axi.sv
// Sram-like responder that turns each accepted request into one single-beat AXI3
// read or write. Only one transaction is in flight at a time.
module sram_like_to_axi #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // sram-like side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        resp_err,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_hs, w_hs;

  // Byte lanes touched by a store of the given size at the given low address bits.
  function automatic logic [3:0] strb_for(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    strb_for = 4'b0001 << lane;
      2'd1:    strb_for = lane[1] ? 4'b1100 : 4'b0011;
      default: strb_for = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    resp_err     = 1'b0;
    data_rdata   = 32'd0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    case (state_q)
      IDLE: begin
        data_addr_ok = data_req;
        if (data_req) begin
          addr_d  = data_addr;
          size_d  = data_size;
          wr_d    = data_wr;
          wdata_d = data_wdata;
          state_d = data_wr ? WADDR : RADDR;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok = 1'b1;
          data_rdata   = rdata;
          resp_err     = (rresp != 2'b00);
          state_d      = IDLE;
        end
      end
      WADDR: begin
        // AW and W retire independently; leave once both have, this cycle included.
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        aw_hs   = ~aw_done_q & awready;
        w_hs    = ~w_done_q & wready;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WRESP;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          resp_err     = (bresp != 2'b00);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;

  // Strobes are only driven while a write is in its address/data phase.
  assign wid     = WR_ID;
  assign wdata   = wdata_q;
  assign wstrb   = (state_q == WADDR) ? strb_for(size_q, addr_q[1:0]) : 4'b0000;
  assign wlast   = 1'b1;

  logic unused_axi;
  assign unused_axi = ^{rid, rlast, bid};

endmodule

// File: doc/sram_like_to_axi.md
Name: sram_like_to_axi

Overview:
- Responder end of the sram-like data interface: accepts sram-like requests from the CPU-side data port and executes each one as a single-beat AXI3 master transaction.
- Returns addr_ok/data_ok handshakes to the sram-like initiator.
- Sits between the data-side sram-to-sram-like converter and the AXI interconnect.
- One outstanding transaction at a time.

Parameters:
- RD_ID, 4'd0, value driven on arid.
- WR_ID, 4'd1, value driven on awid and wid.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_req  in  1  sram-like request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  byte address; reads arrive word-aligned.
- data_wdata  in  32  write data, lane-positioned.
- data_rdata  out  32  read data; valid only while data_ok is high.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  transaction complete this cycle; 1-cycle pulse.
- resp_err  out  1  1-cycle pulse alongside data_ok when rresp or bresp is non-zero.
- arid/araddr/arlen/arsize/arburst  out  4/32/4/3/2  AR channel fields.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel.
- rready  out  1  R ready.
- awid/awaddr/awlen/awsize/awburst  out  4/32/4/3/2  AW channel fields.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- wid/wdata/wstrb/wlast  out  4/32/4/1  W channel fields.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- bid/bresp/bvalid  in  4/2/1  B channel.
- bready  out  1  B ready.

Behaviour:
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP. Reset state is IDLE.
- Reset values: every output is 0 except the fixed constants (arid, awid, wid, arlen, awlen, arburst, awburst, wlast). Request registers clear to 0.
- IDLE:
  - data_addr_ok = data_req, combinational.
  - On req, latch addr, size, wr and wdata.
  - Next state is WADDR if wr, else RADDR.
  - No other state ever asserts addr_ok, so there is exactly one outstanding request.
- Fixed AXI fields: arlen = awlen = 0, arburst = awburst = 2'b01, wlast = 1.
- Size and address: arsize = awsize = {1'b0, latched size}. araddr and awaddr = latched addr, unmodified.
- wstrb derived from latched size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
  - size 3: treated as size 2.
- RADDR: arvalid = 1. When arready is high, go to RDATA. arvalid is never withdrawn before the handshake.
- RDATA:
  - rready = 1.
  - On rvalid: data_data_ok = 1, data_rdata = rdata (combinational pass-through), resp_err = (rresp != 0), then go to IDLE.
  - rid and rlast are ignored.
- WADDR:
  - awvalid and wvalid both start high.
  - Two flags, aw_done and w_done, each set on its own handshake.
  - awvalid = ~aw_done and wvalid = ~w_done, so AW and W complete independently in either order or in the same cycle.
  - When both are done (counting the current cycle's handshakes), go to WRESP and clear the flags.
- WRESP:
  - bready = 1.
  - On bvalid: data_data_ok = 1, resp_err = (bresp != 0), then go to IDLE. data_rdata is don't-care.
- Latency:
  - addr_ok is combinational with req in IDLE.
  - Best-case read: data_ok 2 cycles after addr_ok (arready and rvalid each on the first possible cycle).
  - Best-case write: data_ok 2 cycles after addr_ok.
- addr_ok and data_ok are never high in the same cycle.
- A new request can be accepted the cycle after data_ok.
- All AXI outputs come from latched request registers, so they are stable while valid is high regardless of sram-side input changes.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and all valid/ready outputs drop. Reset is permitted only when the whole system is reset.

Test Plan:
- Word read: req, wr=0, addr=0x1FC0_0010, size=2; arready and rvalid immediate, rdata=0xDEADBEEF -> addr_ok at T0; araddr=0x1FC00010, arsize=2 at T1; data_ok with data_rdata=0xDEADBEEF at T2.
- Byte write: addr=0x8000_0003, size=0, wdata=0x11000000 -> wstrb=4'b1000, awsize=0; data_ok on the bvalid cycle.
- AW/W skew: awready held 0 for 3 cycles while wready=1 -> wvalid drops after 1 cycle; awvalid stays high until accepted; bready high only afterwards; exactly one data_ok.
- Back-pressure: req held high through a read with 5-cycle rvalid delay -> addr_ok only in IDLE; second request accepted the cycle after data_ok.
- Error: bresp=2'b10 on a half-word write at addr[1]=1 -> wstrb=4'b1100; resp_err and data_ok pulse together for exactly 1 cycle.
- Reset while in RDATA -> next cycle arvalid=rready=0, data_ok=0, FSM in IDLE; a fresh read completes normally.
